pll_lock_supervisor: RTL
========================

Name: pll_lock_supervisor

Overview:
Sequences the iCE40 PLL primitive wrapper during bring-up and fault recovery. Runs on the raw board oscillator, so it never depends on the PLL output clock it supervises.
- Drives the PLL's RESETB input.
- Qualifies the asynchronous LOCK output.
- Holds the core reset asserted until lock has been stable for a programmable time.
- Recovers from lock loss by re-resetting the PLL, with bounded retries and a latched fault.

Parameters:
PLL_RESET_CYCLES, 16, cycles pll_resetb held low per attempt (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before an attempt fails
LOCK_STABLE_CYCLES, 1024, consecutive synced-lock-high cycles required before release
MAX_RETRIES, 3, consecutive failed attempts before FAULT (>=1)
LOSS_CNT_W, 8, width of lock-loss counter

Ports:
clock_in  in  1  oscillator clock (18 MHz), sole clock of this block
reset_n  in  1  asynchronous, active-low reset
pll_locked  in  1  PLL LOCK, asynchronous to clock_in
restart  in  1  single-cycle pulse: abort current state, restart sequence, clear retry count
pll_resetb  out  1  to PLL RESETB; 0 = PLL held in reset
core_reset_n  out  1  core reset request; 0 = core in reset (core-domain synchronizer is external)
ready  out  1  1 only in RUN
fault  out  1  1 only in FAULT
lock_loss_count  out  LOSS_CNT_W  saturating count of lock losses seen in RUN

Behaviour:
- pll_locked passes a fixed 2-flop synchronizer (lock_s); all decisions use lock_s. lock_s lags pll_locked by 2 cycles.
- All outputs are registered.
- Values while reset_n=0: state=RESET_PLL, pll_resetb=0, core_reset_n=0, ready=0, fault=0, lock_loss_count=0, retry count=0, timers=0.
- Single shared timer; it is cleared on every state entry.
- RESET_PLL: pll_resetb=0, core_reset_n=0. After PLL_RESET_CYCLES cycles -> WAIT_LOCK.
- WAIT_LOCK: pll_resetb=1, core_reset_n=0.
  - lock_s=1 -> STABLE.
  - Timer reaches LOCK_TIMEOUT_CYCLES-1 with lock_s=0: retry count increments; if the new value equals MAX_RETRIES -> FAULT, else -> RESET_PLL.
- STABLE: pll_resetb=1, core_reset_n=0.
  - lock_s=0 -> WAIT_LOCK. Timer cleared; the timeout restarts from 0; no retry is charged.
  - LOCK_STABLE_CYCLES consecutive cycles of lock_s=1 -> RUN. Retry count is cleared.
- RUN: pll_resetb=1, core_reset_n=1, ready=1.
  - A lock-loss event increments lock_loss_count, saturating at all-ones.
  - The same edge drives core_reset_n=0 and ready=0; state -> RESET_PLL.
  - Lock loss in RUN does not increment the retry count.
- FAULT: pll_resetb=0, core_reset_n=0, fault=1. The state is sticky; only restart or reset_n leaves it.
- restart, any state: next state is RESET_PLL, retry count=0, timer=0. lock_loss_count is preserved.
- restart takes priority over every other transition in the same cycle.
- Minimum latency to RUN, from reset_n deassert with pll_locked already high:
  - PLL_RESET_CYCLES + 2 sync + 1 WAIT_LOCK + LOCK_STABLE_CYCLES cycles.
  - core_reset_n rises in the cycle RUN is entered.
- Timers are sized by $clog2 of the largest of the three cycle parameters.
- Comparisons are exact; no wrap, because the timer is cleared on every state change.

Optional Feature:
Macro PLL_LOCK_GLITCH_FILTER_EN.
- Defined: in RUN, lock loss is declared only after lock_s=0 for 4 consecutive cycles. A low run shorter than 4 cycles is ignored and the filter counter clears. Adds 3 cycles of loss-detection latency.
- Undefined: a single cycle of lock_s=0 in RUN is a loss event.
- WAIT_LOCK and STABLE behave identically in both builds.

Decomposition:
- Shared package pll_supervisor_pkg:
  - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAULT};
  - GLITCH_FILTER_CYCLES=4;
  - SYNC_STAGES=2.
- One sub-module: sync_2ff (generic 2-flop bit synchronizer, async active-low reset to 0), reusable elsewhere.
- The FSM, timer and counters stay in the top module.

Test Plan:
All scenarios use PLL_RESET_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.

1. Clean lock: pll_locked held 1, release reset_n -> pll_resetb rises at cycle 4; core_reset_n and ready rise at cycle 4+2+1+8=15; lock_loss_count=0.
2. Unstable lock: pll_locked 1 for 5 cycles, then low for 1 cycle, then 1 -> no RUN until 8 uninterrupted synced-high cycles; no pll_resetb pulse.
3. Timeout: pll_locked held 0 -> two RESET_PLL pulses 4 cycles wide, each 32 cycles apart; then fault=1 with pll_resetb=0 held. A restart pulse then gives fault=0 and a new attempt; raising pll_locked reaches RUN.
4. Loss in RUN (filter off): pll_locked drops for 1 cycle -> 2 cycles later core_reset_n=0, lock_loss_count=1, pll_resetb low 4 cycles, then re-lock to RUN.
5. Glitch filter (macro on): 3-cycle low -> stays in RUN, count 0. 4-cycle low -> loss, count=1. 256 losses with LOSS_CNT_W=8 -> count saturates at 255.
6. Async reset mid-STABLE, and restart coincident with the timeout in WAIT_LOCK -> all outputs return to reset values immediately; restart wins and the retry count is 0 afterwards.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared types and constants for the PLL lock supervisor: FSM states, the registered
// control-output bundle and its per-state decode, and the timer sizing helper.
package pll_supervisor_pkg;

    typedef enum logic [2:0] {
        RESET_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } state_e;

    localparam int unsigned GLITCH_FILTER_CYCLES = 4;
    localparam int unsigned SYNC_STAGES          = 2;

    typedef struct packed {
        logic pll_resetb;
        logic core_reset_n;
        logic ready;
        logic fault;
    } ctrl_t;

    function automatic ctrl_t drive(input state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            WAIT_LOCK, STABLE: c.pll_resetb = 1'b1;
            RUN: begin
                c.pll_resetb   = 1'b1;
                c.core_reset_n = 1'b1;
                c.ready        = 1'b1;
            end
            FAULT:   c.fault = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // The timer only ever counts up to (limit - 1), so $clog2 of the largest limit suffices.
    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop bit synchronizer with asynchronous active-low reset to 0.
module sync_2ff
    import pll_supervisor_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '0;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL RESETB from the raw oscillator and holds the core in reset until lock is stable.
// Optional build macro PLL_LOCK_GLITCH_FILTER_EN: RUN tolerates lock dropouts shorter than GLITCH_FILTER_CYCLES.
module pll_lock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned PLL_RESET_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned LOSS_CNT_W          = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic                  pll_locked,
    input  logic                  restart,
    output logic                  pll_resetb,
    output logic                  core_reset_n,
    output logic                  ready,
    output logic                  fault,
    output logic [LOSS_CNT_W-1:0] lock_loss_count
);

    localparam int unsigned TIMER_W = timer_width(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                                  LOCK_STABLE_CYCLES);
    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [TIMER_W-1:0] RESET_LAST   = TIMER_W'(PLL_RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

    state_e              state;
    logic [TIMER_W-1:0]  timer;
    logic [RETRY_W-1:0]  retry_cnt;
    logic                lock_s;
    logic                lock_loss;

    // LOCK from a PLL held in reset is meaningless, so it is masked before synchronizing;
    // this also guarantees lock_s re-qualifies from 0 after every RESETB pulse.
    sync_2ff u_lock_sync (
        .clk   (clock_in),
        .rst_n (reset_n),
        .d     (pll_locked & pll_resetb),
        .q     (lock_s)
    );

`ifdef PLL_LOCK_GLITCH_FILTER_EN
    localparam int unsigned LOW_W = $clog2(GLITCH_FILTER_CYCLES);

    logic [LOW_W-1:0] low_cnt;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            low_cnt <= '0;
        end else if (restart || state != RUN || lock_s || lock_loss) begin
            low_cnt <= '0;
        end else begin
            low_cnt <= low_cnt + LOW_W'(1);
        end
    end

    assign lock_loss = (state == RUN) && !lock_s && (low_cnt == LOW_W'(GLITCH_FILTER_CYCLES - 1));
`else
    assign lock_loss = (state == RUN) && !lock_s;
`endif

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state           <= RESET_PLL;
            timer           <= '0;
            retry_cnt       <= '0;
            lock_loss_count <= '0;
            {pll_resetb, core_reset_n, ready, fault} <= drive(RESET_PLL);
        end else if (restart) begin
            state     <= RESET_PLL;
            timer     <= '0;
            retry_cnt <= '0;
            {pll_resetb, core_reset_n, ready, fault} <= drive(RESET_PLL);
        end else begin
            case (state)
                RESET_PLL: begin
                    if (timer == RESET_LAST) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                        {pll_resetb, core_reset_n, ready, fault} <= drive(WAIT_LOCK);
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= STABLE;
                        timer <= '0;
                        {pll_resetb, core_reset_n, ready, fault} <= drive(STABLE);
                    end else if (timer == TIMEOUT_LAST) begin
                        timer     <= '0;
                        retry_cnt <= retry_cnt + RETRY_W'(1);
                        if (retry_cnt == RETRY_LAST) begin
                            state <= FAULT;
                            {pll_resetb, core_reset_n, ready, fault} <= drive(FAULT);
                        end else begin
                            state <= RESET_PLL;
                            {pll_resetb, core_reset_n, ready, fault} <= drive(RESET_PLL);
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state <= WAIT_LOCK;
                        timer <= '0;
                        {pll_resetb, core_reset_n, ready, fault} <= drive(WAIT_LOCK);
                    end else if (timer == STABLE_LAST) begin
                        state     <= RUN;
                        timer     <= '0;
                        retry_cnt <= '0;
                        {pll_resetb, core_reset_n, ready, fault} <= drive(RUN);
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RUN: begin
                    timer <= '0;
                    if (lock_loss) begin
                        state <= RESET_PLL;
                        {pll_resetb, core_reset_n, ready, fault} <= drive(RESET_PLL);
                        if (lock_loss_count != '1) begin
                            lock_loss_count <= lock_loss_count + LOSS_CNT_W'(1);
                        end
                    end
                end
                FAULT: begin
                    timer <= '0;
                end
                default: begin
                    state <= RESET_PLL;
                    timer <= '0;
                    {pll_resetb, core_reset_n, ready, fault} <= drive(RESET_PLL);
                end
            endcase
        end
    end

endmodule
